// File: rtl/lcd_pkg.sv
// Shared LCD definitions for the HD44780 reader and writer controllers:
// state encoding, default 50 MHz timing, register-select and busy-flag constants.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EN_HI,
    ST_HOLD,
    ST_PAD,
    ST_DONE
  } lcd_state_t;

  localparam int unsigned T_AS_DEF     = 3;
  localparam int unsigned T_EN_DEF     = 25;
  localparam int unsigned T_H_DEF      = 3;
  localparam int unsigned T_CYC_DEF    = 50;
  localparam int unsigned POLL_MAX_DEF = 2000;

  localparam logic RS_INSTR = 1'b0;
  localparam logic RS_DATA  = 1'b1;

  localparam int unsigned BF_BIT = 7;

endpackage

// File: rtl/lcd_reader_if.sv
// Request/response handshake between a client and the LCD read engine.
interface lcd_reader_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic       req_poll;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_timeout;

  modport master (
    output req_valid, req_rs, req_poll,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout
  );

  modport slave (
    input  req_valid, req_rs, req_poll,
    output req_ready, rsp_valid, rsp_data, rsp_timeout
  );
endinterface

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter for LCD bus phases; done is high once the count reaches zero.
module lcd_phase_timer #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_reader.sv
// HD44780 read engine: single busy-flag/data reads or busy-flag polling,
// driving RS/RW/EN while it owns the bus.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int unsigned T_AS     = T_AS_DEF,
  parameter int unsigned T_EN     = T_EN_DEF,
  parameter int unsigned T_H      = T_H_DEF,
  parameter int unsigned T_CYC    = T_CYC_DEF,
  parameter int unsigned POLL_MAX = POLL_MAX_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  lcd_reader_if.slave  host,
  input  logic [7:0]   lcd_data_in,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic         bus_own
);

  if (T_CYC < T_AS + T_EN + T_H || T_AS == 0 || T_EN == 0 || T_H == 0 || POLL_MAX == 0)
  begin : g_bad_timing
    $error("lcd_reader: invalid timing parameters");
  end

  localparam int unsigned T_PAD = T_CYC - T_AS - T_EN - T_H;
  localparam int unsigned PH_W  = $clog2(T_CYC + 1);
  localparam int unsigned PC_W  = $clog2(POLL_MAX + 1);

  lcd_state_t      state_q, state_d;
  logic            ph_load, ph_done;
  logic [PH_W-1:0] ph_val;
  logic            accept, sample, end_read, end_timeout, poll_inc;
  logic            rs_q, rs_d, poll_q, busy_d, more_polls;
  logic [PC_W-1:0] poll_cnt_q;
  logic [7:0]      data_q;
  logic            timeout_q, rsp_valid_q, ready_q;

  lcd_phase_timer #(.W(PH_W)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (ph_load),
    .load_val (ph_val),
    .done     (ph_done)
  );

  assign accept     = (state_q == ST_IDLE) && host.req_valid && ready_q;
  assign rs_d       = accept ? (host.req_poll ? RS_INSTR : host.req_rs) : rs_q;
  assign more_polls = (32'(poll_cnt_q) + 32'd1) < POLL_MAX;

  always_comb begin
    state_d     = state_q;
    sample      = 1'b0;
    end_read    = 1'b0;
    end_timeout = 1'b0;
    poll_inc    = 1'b0;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: if (ph_done) state_d = ST_EN_HI;
      ST_EN_HI: if (ph_done) begin
                  sample  = 1'b1;
                  state_d = ST_HOLD;
                end
      ST_HOLD:  if (ph_done) begin
                  if (T_PAD != 0) state_d = ST_PAD;
                  else            end_read = 1'b1;
                end
      ST_PAD:   if (ph_done) end_read = 1'b1;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // A busy poll loops straight back into SETUP, keeping the bus.
    if (end_read) begin
      if (poll_q && data_q[BF_BIT]) begin
        if (more_polls) begin
          poll_inc = 1'b1;
          state_d  = ST_SETUP;
        end else begin
          end_timeout = 1'b1;
          state_d     = ST_DONE;
        end
      end else begin
        state_d = ST_DONE;
      end
    end

    ph_load = (state_d != state_q);
    case (state_d)
      ST_SETUP: ph_val = PH_W'(T_AS - 1);
      ST_EN_HI: ph_val = PH_W'(T_EN - 1);
      ST_HOLD:  ph_val = PH_W'(T_H - 1);
      ST_PAD:   ph_val = PH_W'(T_PAD - 1);
      default:  ph_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  assign busy_d = (state_d == ST_SETUP) || (state_d == ST_EN_HI) ||
                  (state_d == ST_HOLD)  || (state_d == ST_PAD);

  // Pins are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rs_q        <= 1'b0;
      poll_q      <= 1'b0;
      poll_cnt_q  <= '0;
      data_q      <= '0;
      timeout_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      lcd_rs      <= 1'b0;
      lcd_rw      <= 1'b0;
      lcd_en      <= 1'b0;
      bus_own     <= 1'b0;
    end else begin
      if (accept) begin
        rs_q       <= rs_d;
        poll_q     <= host.req_poll;
        poll_cnt_q <= '0;
      end else if (poll_inc) begin
        poll_cnt_q <= poll_cnt_q + 1'b1;
      end
      if (sample)              data_q    <= lcd_data_in;
      if (state_d == ST_DONE)  timeout_q <= end_timeout;
      rsp_valid_q <= (state_d == ST_DONE);
      ready_q     <= (state_d == ST_IDLE);
      bus_own     <= busy_d;
      lcd_rw      <= busy_d;
      lcd_rs      <= busy_d & rs_d;
      lcd_en      <= (state_d == ST_EN_HI);
    end
  end

  assign host.req_ready   = ready_q;
  assign host.rsp_valid   = rsp_valid_q;
  assign host.rsp_data    = data_q;
  assign host.rsp_timeout = timeout_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Bench for lcd_reader: directed and random read/poll transactions against a
// cycle-timeline model derived from the read timing rules.
module tb_lcd_reader;
  import lcd_pkg::*;

  localparam int unsigned TAS  = T_AS_DEF;
  localparam int unsigned TEN  = T_EN_DEF;
  localparam int unsigned TH   = T_H_DEF;
  localparam int unsigned TCYC = T_CYC_DEF;
  localparam int unsigned TPM  = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] lcd_data_in = 8'h00;
  logic       lcd_rs, lcd_rw, lcd_en, bus_own;

  lcd_reader_if host ();

  lcd_reader #(
    .T_AS     (TAS),
    .T_EN     (TEN),
    .T_H      (TH),
    .T_CYC    (TCYC),
    .POLL_MAX (TPM)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .host        (host),
    .lcd_data_in (lcd_data_in),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_en      (lcd_en),
    .bus_own     (bus_own)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  bytes [4];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [5:0] pins_now();
    return {host.req_ready, host.rsp_valid, bus_own, lcd_rw, lcd_rs, lcd_en};
  endfunction

  // One request; the LCD returns bytes[k] on the k-th EN pulse and junk afterwards.
  task automatic run_txn(input logic rs, input logic poll, input bit keep_valid,
                         input int unsigned poke_at);
    int unsigned n, n_end, p, k;
    logic        tmo, rs_exp, act, en;
    logic [5:0]  exp;
    n = 1;
    if (poll) while (n < TPM && bytes[n-1][BF_BIT]) n++;
    tmo    = poll && bytes[n-1][BF_BIT];
    rs_exp = poll ? RS_INSTR : rs;
    n_end  = n * TCYC;

    host.req_rs    = rs;
    host.req_poll  = poll;
    host.req_valid = 1'b1;
    @(posedge clk);
    for (int unsigned c = 1; c <= n_end + 2; c++) begin
      @(negedge clk);
      if (c == 1 && !keep_valid) host.req_valid = 1'b0;
      if (poke_at != 0 && c == poke_at)     host.req_valid = 1'b1;
      if (poke_at != 0 && c == poke_at + 1) host.req_valid = 1'b0;
      p   = (c - 1) % TCYC;
      k   = (c - 1) / TCYC;
      act = (c <= n_end);
      en  = act && p >= TAS && p < TAS + TEN;
      exp = {c >= n_end + 2, c == n_end + 1, act, act, act && rs_exp, en};
      check($sformatf("pins c=%0d", c), 32'(pins_now()), 32'(exp));
      if (c == n_end + 1) begin
        check("rsp_data", 32'(host.rsp_data), 32'(bytes[n-1]));
        check("rsp_timeout", 32'(host.rsp_timeout), 32'(tmo));
      end
      if (act && p == TAS)       lcd_data_in = bytes[k];
      if (act && p == TAS + TEN) lcd_data_in = ~bytes[k];
    end
  endtask

  task automatic idle_quiet(input int unsigned cycles);
    int unsigned cnt = 0;
    for (int unsigned i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus_own || lcd_en || host.rsp_valid) cnt++;
    end
    check("idle_quiet", cnt, 0);
  endtask

  initial begin
    host.req_valid = 1'b0;
    host.req_rs    = 1'b0;
    host.req_poll  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset pins", 32'(pins_now()), 32'(6'b100000));
    check("reset rsp_data", 32'(host.rsp_data), 32'h00);
    check("reset rsp_timeout", 32'(host.rsp_timeout), 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    bytes = '{8'h41, 8'h00, 8'h00, 8'h00};
    run_txn(RS_DATA, 1'b0, 1'b0, 0);
    bytes = '{8'h8F, 8'h00, 8'h00, 8'h00};
    run_txn(RS_INSTR, 1'b0, 1'b0, 0);
    bytes = '{8'h85, 8'h85, 8'h85, 8'h05};
    run_txn(RS_DATA, 1'b1, 1'b0, 0);
    bytes = '{8'h80, 8'h80, 8'h80, 8'h80};
    run_txn(RS_INSTR, 1'b1, 1'b0, 0);

    bytes = '{8'h3C, 8'h00, 8'h00, 8'h00};
    run_txn(RS_DATA, 1'b0, 1'b1, 0);
    bytes = '{8'hC3, 8'h00, 8'h00, 8'h00};
    run_txn(RS_DATA, 1'b0, 1'b0, 0);

    bytes = '{8'h27, 8'h00, 8'h00, 8'h00};
    run_txn(RS_DATA, 1'b0, 1'b0, 30);
    idle_quiet(60);

    // Reset while EN is high must drop the pins without waiting for a clock.
    bytes = '{8'h5A, 8'h00, 8'h00, 8'h00};
    host.req_rs    = RS_DATA;
    host.req_poll  = 1'b0;
    host.req_valid = 1'b1;
    @(posedge clk);
    for (int unsigned c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) host.req_valid = 1'b0;
    end
    check("en before reset", 32'(lcd_en), 32'h1);
    #2 rstn = 1'b0;
    #1;
    check("en async reset", 32'(lcd_en), 32'h0);
    check("own async reset", 32'(bus_own), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    check("ready after reset", 32'(host.req_ready), 32'h1);
    idle_quiet(60);

    for (int unsigned t = 0; t < 12; t++) begin
      for (int unsigned b = 0; b < 4; b++) begin
        bytes[b] = 8'($urandom);
        bytes[b][BF_BIT] = ($urandom_range(0, 3) != 0);
      end
      run_txn(1'($urandom), 1'($urandom), (t < 11) && ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 1) == 1) ? $urandom_range(2, 40) : 0);
    end
    host.req_valid = 1'b0;
    idle_quiet(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
